div_iter: RTL and testbench

Iterative radix-2 integer divider for the MDU, covering RISC-V DIV, DIVU, REM and REMU. It accepts one operation at a time through a start/busy/done handshake and produces one XLEN-bit result. It runs one shift-subtract step per cycle on absolute-value operands and applies sign correction at the end. Divide-by-zero and signed overflow are resolved early without iterating.

---
 rtl/div_iter.sv | 190 +++++++++++++++++++
 tb/tb_div_iter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter
// Iterative radix-2 integer divider for the MDU. It implements the RISC-V
// DIV, DIVU, REM and REMU operations. The divider works on the magnitudes of
// the operands and runs one shift-subtract step per cycle. Sign correction is
// applied in a single fix-up cycle at the end. Divide-by-zero and signed
// overflow are resolved in the accept cycle, so they skip the iteration.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   reset          asynchronous, active-low reset
//   FlushE         synchronous abort of any in-flight operation
//   DivStartE      request a new divide; sampled only in IDLE
//   Funct3E        bit1 = remainder, bit0 = unsigned (bit2 is ignored)
//   ForwardedSrcAE dividend
//   ForwardedSrcBE divisor
//   DivBusyE       operation in progress (ITER/FIX)
//   DivDoneM       one-cycle pulse, DivResultM is valid
//   DivResultM     quotient or remainder, held until the next DivDoneM
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for DivStartE; operands are captured on accept
// ITER  | one shift-subtract step per cycle, XLEN cycles in total
// FIX   | apply sign correction and select quotient or remainder
// DONE  | DivDoneM pulse; DivResultM valid
// -----------------------------------------------------------------------------
module div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            FlushE,
    input  logic            DivStartE,
    input  logic [2:0]      Funct3E,
    input  logic [XLEN-1:0] ForwardedSrcAE,
    input  logic [XLEN-1:0] ForwardedSrcBE,
    output logic            DivBusyE,
    output logic            DivDoneM,
    output logic [XLEN-1:0] DivResultM
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] divb_q, divb_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            rem_sel_q, rem_sel_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;

    // Operand decode in the accept cycle
    logic            is_signed;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            div_zero, sgn_ovf;

    // Iteration datapath
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] quo_fix, rem_fix;

    // Funct3E[2] is don't-care: all encodings decode on bit1/bit0 only.
    logic unused_f3;
    assign unused_f3 = Funct3E[2];

    assign is_signed = ~Funct3E[0];
    assign a_neg     = is_signed & ForwardedSrcAE[XLEN-1];
    assign b_neg     = is_signed & ForwardedSrcBE[XLEN-1];
    assign a_abs     = a_neg ? (~ForwardedSrcAE + 1'b1) : ForwardedSrcAE;
    assign b_abs     = b_neg ? (~ForwardedSrcBE + 1'b1) : ForwardedSrcBE;
    assign div_zero  = (ForwardedSrcBE == '0);
    assign sgn_ovf   = is_signed
                     & (ForwardedSrcAE == {1'b1, {(XLEN-1){1'b0}}})
                     & (ForwardedSrcBE == {XLEN{1'b1}});

    // Partial remainder picks up the next dividend bit from the quotient
    // register's MSB; the extra top bit makes the trial sign visible.
    assign rem_sh  = {rem_q, quo_q[XLEN-1]};
    assign trial   = rem_sh - {1'b0, divb_q};

    assign quo_fix = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
    assign rem_fix = neg_rem_q ? (~rem_q + 1'b1) : rem_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divb_q    <= '0;
            result_q  <= '0;
            rem_sel_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divb_q    <= divb_d;
            result_q  <= result_d;
            rem_sel_q <= rem_sel_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divb_d    = divb_q;
        result_d  = result_q;
        rem_sel_d = rem_sel_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        case (state_q)
            IDLE: begin
                if (DivStartE && !FlushE) begin
                    rem_sel_d = Funct3E[1];
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    if (div_zero) begin
                        result_d = Funct3E[1] ? ForwardedSrcAE : {XLEN{1'b1}};
                        state_d  = DONE;
                    end else if (sgn_ovf) begin
                        result_d = Funct3E[1] ? '0 : ForwardedSrcAE;
                        state_d  = DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = a_abs;
                        divb_d  = b_abs;
                        cnt_d   = CNT_LAST;
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                if (!trial[XLEN]) begin
                    rem_d = trial[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                result_d = rem_sel_q ? rem_fix : quo_fix;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over everything, including a same-cycle start; the
        // visible result stays at its last completed value.
        if (FlushE) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    assign DivBusyE   = (state_q == ITER) || (state_q == FIX);
    assign DivDoneM   = (state_q == DONE);
    assign DivResultM = result_q;

endmodule

// File: tb/tb_div_iter.sv
module tb_div_iter;

    localparam int XLEN = 32;

    logic            clk;
    logic            reset;
    logic            FlushE;
    logic            DivStartE;
    logic [2:0]      Funct3E;
    logic [XLEN-1:0] ForwardedSrcAE;
    logic [XLEN-1:0] ForwardedSrcBE;
    logic            DivBusyE;
    logic            DivDoneM;
    logic [XLEN-1:0] DivResultM;

    div_iter #(.XLEN(XLEN)) dut (
        .clk            (clk),
        .reset          (reset),
        .FlushE         (FlushE),
        .DivStartE      (DivStartE),
        .Funct3E        (Funct3E),
        .ForwardedSrcAE (ForwardedSrcAE),
        .ForwardedSrcBE (ForwardedSrcBE),
        .DivBusyE       (DivBusyE),
        .DivDoneM       (DivDoneM),
        .DivResultM     (DivResultM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          done_cyc;
        string       name;
    } exp_t;

    exp_t        sbq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_res = '0;
    int          last_acc = 0;
    int          last_done = 0;

    // Reference: plain 64-bit arithmetic on the operand values.
    function automatic logic [31:0] ref_div(input logic [2:0] f,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint q, r, sa, sb;
        if (!f[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        if (b == 32'd0) begin
            q = -1;
            r = sa;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return f[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'($urandom_range(0, 200)) - 32'd100;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Record the expected completion of an operation accepted this cycle.
    task automatic push_exp(input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] b, input string nm);
        exp_t e;
        bit   special;
        special    = (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        e.res      = ref_div(f, a, b);
        e.done_cyc = cyc + (special ? 1 : XLEN + 2);
        e.name     = nm;
        sbq.push_back(e);
        last_res   = e.res;
        last_acc   = cyc;
        last_done  = e.done_cyc;
    endtask

    // Must be called while the DUT is in IDLE.
    task automatic start_op(input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] b, input string nm);
        Funct3E        = f;
        ForwardedSrcAE = a;
        ForwardedSrcBE = b;
        DivStartE      = 1'b1;
        push_exp(f, a, b, nm);
        step();
        DivStartE      = 1'b0;
        // Scramble operands: only the accept-cycle values may matter.
        Funct3E        = 3'($urandom);
        ForwardedSrcAE = $urandom;
        ForwardedSrcBE = $urandom;
    endtask

    // Walk to the expected done cycle checking busy, then one more into IDLE.
    task automatic wait_done(input string nm);
        bit busy_bad = 0;
        int n = 0;
        while (cyc < last_done && n < 200) begin
            if (DivBusyE !== (cyc >= last_acc + 1)) busy_bad = 1;
            step();
            n++;
        end
        check({nm, "_busy_window"}, {31'd0, busy_bad}, 32'd0);
        check({nm, "_done_pulse"}, {31'd0, DivDoneM}, 32'd1);
        check({nm, "_busy_at_done"}, {31'd0, DivBusyE}, 32'd0);
        step();
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input string nm);
        start_op(f, a, b, nm);
        wait_done(nm);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset && DivDoneM) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: DivDoneM=1 with no operation pending (cycle %0d), result 0x%08h",
                         cyc, DivResultM);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check({e.name, "_result"}, DivResultM, e.res);
                check({e.name, "_done_cycle"}, 32'(cyc), 32'(e.done_cyc));
            end
        end
    end

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prev;
        int          acc0;
        int          next_acc;
        int          count;
        logic [2:0]  f;
        logic [31:0] a, b;

        reset          = 1'b0;
        FlushE         = 1'b0;
        DivStartE      = 1'b0;
        Funct3E        = 3'd0;
        ForwardedSrcAE = '0;
        ForwardedSrcBE = '0;
        step();
        step();
        check("reset_busy", {31'd0, DivBusyE}, 32'd0);
        check("reset_done", {31'd0, DivDoneM}, 32'd0);
        check("reset_result", DivResultM, 32'd0);
        reset = 1'b1;
        step();

        // Directed cases
        run_op(3'b100, 32'd100, 32'd7, "div_100_7");
        run_op(3'b110, 32'd100, 32'd7, "rem_100_7");
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        run_op(3'b110, 32'd7, 32'hFFFF_FFFE, "rem_7_m2");
        run_op(3'b100, 32'hFFFF_FFF9, 32'hFFFF_FFFE, "div_m7_m2");
        run_op(3'b101, 32'hFFFF_FFFF, 32'h10, "divu_max_16");
        run_op(3'b111, 32'hFFFF_FFFF, 32'h10, "remu_max_16");
        run_op(3'b100, 32'd1234, 32'd0, "div_by_zero");
        run_op(3'b111, 32'd1234, 32'd0, "remu_by_zero");
        run_op(3'b110, 32'hFFFF_FB2E, 32'd0, "rem_neg_by_zero");
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, "divu_no_ovf");
        run_op(3'b000, 32'hFFFF_FF9C, 32'd7, "f3_000_div");
        run_op(3'b011, 32'hFFFF_FF9C, 32'd7, "f3_011_remu");

        // Flush mid-operation, then a fresh start two cycles later
        prev = last_res;
        acc0 = cyc;
        start_op(3'b100, 32'd100, 32'd7, "flushed");
        void'(sbq.pop_back());
        last_res = prev;
        while (cyc < acc0 + 10) step();
        FlushE = 1'b1;
        step();
        FlushE = 1'b0;
        check("flush_busy_low", {31'd0, DivBusyE}, 32'd0);
        check("flush_result_held", DivResultM, prev);
        step();
        start_op(3'b101, 32'd50, 32'd5, "divu_after_flush");
        check("after_flush_done_cycle", 32'(last_done - acc0), 32'd46);
        wait_done("divu_after_flush");

        // Start together with flush is dropped
        FlushE         = 1'b1;
        DivStartE      = 1'b1;
        Funct3E        = 3'b100;
        ForwardedSrcAE = 32'd9;
        ForwardedSrcBE = 32'd3;
        step();
        FlushE    = 1'b0;
        DivStartE = 1'b0;
        begin
            bit busy_seen = 0;
            for (int i = 0; i < 4; i++) begin
                if (DivBusyE !== 1'b0 || DivDoneM !== 1'b0) busy_seen = 1;
                step();
            end
            check("start_with_flush_dropped", {31'd0, busy_seen}, 32'd0);
        end

        // Back-to-back: DONE at 34, next accepted at 35, DONE at 69
        acc0 = cyc;
        start_op(3'b100, 32'd1000, 32'd33, "b2b_first");
        wait_done("b2b_first");
        check("b2b_second_accept", 32'(cyc - acc0), 32'(XLEN + 3));
        start_op(3'b110, 32'd1000, 32'd33, "b2b_second");
        check("b2b_second_done", 32'(last_done - acc0), 32'd69);
        wait_done("b2b_second");

        // DivStartE held high with operands changing every cycle
        DivStartE = 1'b1;
        next_acc  = cyc;
        count     = 0;
        for (int g = 0; g < 400; g++) begin
            f              = 3'($urandom);
            a              = rand_val();
            b              = rand_val();
            Funct3E        = f;
            ForwardedSrcAE = a;
            ForwardedSrcBE = b;
            if (cyc == next_acc && count < 4) begin
                push_exp(f, a, b, $sformatf("held_start_%0d", count));
                next_acc = last_done + 1;
                count++;
            end
            if (count == 4 && cyc == last_done) begin
                DivStartE = 1'b0;
                step();
                break;
            end
            step();
        end
        check("held_start_ops", 32'(count), 32'd4);
        step();

        // Randomized operations
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom);
            a = rand_val();
            b = rand_val();
            run_op(f, a, b, $sformatf("rand_%0d_f%0d", i, f));
        end

        // Reset asserted mid-operation
        acc0 = cyc;
        start_op(3'b100, 32'd100, 32'd7, "reset_mid");
        while (cyc < acc0 + 5) step();
        reset = 1'b0;
        #1;
        sbq.delete();
        check("midreset_busy", {31'd0, DivBusyE}, 32'd0);
        check("midreset_done", {31'd0, DivDoneM}, 32'd0);
        check("midreset_result", DivResultM, 32'd0);
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 40; i++) step();
        run_op(3'b111, 32'd77, 32'd10, "after_reset_remu");

        step();
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
